// File: rtl/dma_peripheral_responder.sv
// Peripheral endpoint of an 8237-style DMA channel: DREQ/DACK handshake, single-byte
// IOR_N/IOW_N transfers, and local IN (device->memory) / OUT (memory->device) FIFOs.
module dma_peripheral_responder #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  output logic             DREQ,
  input  logic             DACK,
  input  logic             IOR_N,
  input  logic             IOW_N,
  input  logic             EOP_N,
  input  logic [WIDTH-1:0] DB_IN,
  output logic [WIDTH-1:0] DB_OUT,
  output logic             DB_OE,
  input  logic             enable,
  input  logic             dir,
  input  logic             in_push,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_full,
  input  logic             out_pop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_empty,
  output logic             eop_seen,
  output logic             err,
  input  logic             flag_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    REQ     = 4'b0010,
    XFER    = 4'b0100,
    RELEASE = 4'b1000
  } state_e;

  state_e           state_q, state_d;
  logic             dreq_q, dreq_d;
  logic             dir_q, dir_d;
  logic             eop_q, eop_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [PTR_W-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [WIDTH-1:0] in_mem  [DEPTH];
  logic [WIDTH-1:0] out_mem [DEPTH];

  logic ior_act, iow_act, eop_act;
  logic in_empty_w, in_full_w, out_empty_w, out_full_w;
  logic rd_xfer, wr_xfer, wrong_strobe;
  logic dma_pop, dma_push, in_push_ok, out_pop_ok;
  logic eop_set, err_set, db_oe;

  // Only a solid 0 is a strobe; a floating (z/x) line must never start a transfer.
  assign ior_act = (IOR_N === 1'b0);
  assign iow_act = (IOW_N === 1'b0);
  assign eop_act = (EOP_N === 1'b0);

  assign in_empty_w  = (in_cnt_q == '0);
  assign in_full_w   = (in_cnt_q == FULL_CNT);
  assign out_empty_w = (out_cnt_q == '0);
  assign out_full_w  = (out_cnt_q == FULL_CNT);

  assign rd_xfer      = DACK && ior_act && !dir_q;
  assign wr_xfer      = DACK && iow_act && dir_q;
  assign wrong_strobe = DACK && (dir_q ? ior_act : iow_act);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    eop_set  = 1'b0;
    err_set  = 1'b0;
    dma_pop  = 1'b0;
    dma_push = 1'b0;
    db_oe    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && ((!dir && !in_empty_w) || (dir && !out_full_w))) begin
          state_d = REQ;
          dir_d   = dir;
        end
      end
      REQ: begin
        if (eop_act) begin
          state_d = IDLE;
          eop_set = 1'b1;
        end else if (DACK) begin
          state_d = XFER;
        end
      end
      XFER: begin
        db_oe   = rd_xfer;
        err_set = wrong_strobe;
        eop_set = eop_act;
        if (rd_xfer) begin
          if (in_empty_w) err_set = 1'b1;
          else            dma_pop = 1'b1;
          state_d = RELEASE;
        end else if (wr_xfer) begin
          if (out_full_w) err_set  = 1'b1;
          else            dma_push = 1'b1;
          state_d = RELEASE;
        end else if (eop_act) begin
          state_d = RELEASE;
        end else if (!DACK) begin
          state_d = IDLE;
        end
      end
      RELEASE: begin
        if (!DACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dreq_d     = (state_d == REQ);
    eop_d      = flag_clr ? 1'b0 : (eop_q | eop_set);
    err_d      = flag_clr ? 1'b0 : (err_q | err_set);
    // A push into a full IN FIFO is still accepted when the DMA pops on the same edge.
    in_push_ok = in_push && (!in_full_w || dma_pop);
    out_pop_ok = out_pop && !out_empty_w;
    in_wr_d    = in_wr_q + PTR_W'(in_push_ok);
    in_rd_d    = in_rd_q + PTR_W'(dma_pop);
    in_cnt_d   = in_cnt_q + CNT_W'(in_push_ok) - CNT_W'(dma_pop);
    out_wr_d   = out_wr_q + PTR_W'(dma_push);
    out_rd_d   = out_rd_q + PTR_W'(out_pop_ok);
    out_cnt_d  = out_cnt_q + CNT_W'(dma_push) - CNT_W'(out_pop_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      dreq_q    <= 1'b0;
      dir_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      in_cnt_q  <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dreq_q    <= dreq_d;
      dir_q     <= dir_d;
      eop_q     <= eop_d;
      err_q     <= err_d;
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      in_cnt_q  <= in_cnt_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // NOTE: storage arrays carry no reset; the counts alone decide which entries are valid.
  always_ff @(posedge CLK) begin
    if (in_push_ok) in_mem[in_wr_q]   <= in_data;
    if (dma_push)   out_mem[out_wr_q] <= DB_IN;
  end

  assign DREQ      = dreq_q;
  assign DB_OE     = db_oe;
  assign DB_OUT    = db_oe ? in_mem[in_rd_q] : '0;
  assign in_full   = in_full_w;
  assign out_data  = out_mem[out_rd_q];
  assign out_empty = out_empty_w;
  assign eop_seen  = eop_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dma_peripheral_responder.sv
// Self-checking bench for dma_peripheral_responder: directed handshake scenarios with
// literal expectations, then randomized traffic against a queue-based reference model.
module tb_dma_peripheral_responder;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             CLK, RESET_N;
  logic             DREQ, DACK, IOR_N, IOW_N, EOP_N;
  logic [WIDTH-1:0] DB_IN, DB_OUT;
  logic             DB_OE;
  logic             enable, dir, in_push, in_full, out_pop, out_empty;
  logic [WIDTH-1:0] in_data, out_data;
  logic             eop_seen, err, flag_clr;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 0;

  dma_peripheral_responder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N),
    .IOW_N(IOW_N), .EOP_N(EOP_N), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
    .enable(enable), .dir(dir), .in_push(in_push), .in_data(in_data),
    .in_full(in_full), .out_pop(out_pop), .out_data(out_data),
    .out_empty(out_empty), .eop_seen(eop_seen), .err(err), .flag_clr(flag_clr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: protocol phase plus two plain queues standing in for the FIFOs.
  int         m_phase = 0;  // 0 idle, 1 requesting, 2 transferring, 3 releasing
  bit         m_dir   = 0;
  bit         m_eop   = 0;
  bit         m_err   = 0;
  logic [7:0] in_q[$];
  logic [7:0] out_q[$];

  task automatic model_step();
    automatic bit ior = (IOR_N == 1'b0);
    automatic bit iow = (IOW_N == 1'b0);
    automatic bit eop = (EOP_N == 1'b0);
    automatic bit pop_dma = 0, push_dma = 0, popped = 0;
    automatic bit in_room  = (in_q.size() < DEPTH);
    automatic bit out_room = (out_q.size() < DEPTH);
    automatic bit out_has  = (out_q.size() > 0);
    automatic int nxt = m_phase;
    if (!RESET_N) begin
      m_phase = 0; m_dir = 0; m_eop = 0; m_err = 0;
      in_q.delete(); out_q.delete();
      return;
    end
    case (m_phase)
      0: if (enable && (dir ? out_room : (in_q.size() > 0))) begin nxt = 1; m_dir = dir; end
      1: if (eop) begin nxt = 0; m_eop = 1; end else if (DACK) nxt = 2;
      2: begin
        if (DACK && (m_dir ? ior : iow)) m_err = 1;
        if (eop) m_eop = 1;
        if (DACK && !m_dir && ior)     begin pop_dma = 1; nxt = 3; end
        else if (DACK && m_dir && iow) begin push_dma = 1; nxt = 3; end
        else if (eop)                  nxt = 3;
        else if (!DACK)                nxt = 0;
      end
      default: if (!DACK) nxt = 0;
    endcase
    if (pop_dma) begin
      if (in_q.size() == 0) m_err = 1;
      else begin void'(in_q.pop_front()); popped = 1; end
    end
    if (in_push && (in_room || popped)) in_q.push_back(in_data);
    if (out_pop && out_has) void'(out_q.pop_front());
    if (push_dma) begin
      if (!out_room) m_err = 1;
      else out_q.push_back(DB_IN);
    end
    if (flag_clr) begin m_eop = 0; m_err = 0; end
    m_phase = nxt;
  endtask

  always @(posedge CLK or negedge RESET_N) model_step();

  // Compare process: outputs are checked mid-cycle against the model every clock.
  always @(negedge CLK) begin
    if (cmp_on) begin
      automatic bit exp_oe = (m_phase == 2) && !m_dir && DACK && (IOR_N == 1'b0) && (in_q.size() > 0);
      check("m_DREQ", DREQ, (m_phase == 1));
      check("m_DB_OE", DB_OE, exp_oe);
      check("m_DB_OUT", DB_OUT, exp_oe ? in_q[0] : 8'h00);
      check("m_in_full", in_full, (in_q.size() == DEPTH));
      check("m_out_empty", out_empty, (out_q.size() == 0));
      if (out_q.size() > 0) check("m_out_data", out_data, out_q[0]);
      check("m_eop_seen", eop_seen, m_eop);
      check("m_err", err, m_err);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_dreq();
    automatic int n = 0;
    while (DREQ !== 1'b1 && n < 20) begin tick(); n++; end
    if (DREQ !== 1'b1) check("dreq_timeout", DREQ, 1'b1);
  endtask

  task automatic dma_write(input logic [7:0] d);
    wait_dreq();
    DACK = 1'b1; tick();
    IOW_N = 1'b0; DB_IN = d; tick();
    IOW_N = 1'b1; DACK = 1'b0; tick();
  endtask

  task automatic dma_read(input bit push_en, input logic [7:0] push_val, input logic [7:0] exp);
    wait_dreq();
    DACK = 1'b1; tick();
    IOR_N = 1'b0; in_push = push_en; in_data = push_val; #1;
    check("read_oe", DB_OE, 1'b1);
    check("read_data", DB_OUT, exp);
    tick();
    in_push = 1'b0; IOR_N = 1'b1; DACK = 1'b0; tick();
  endtask

  initial begin
    RESET_N = 1'b0; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
    DB_IN = '0; enable = 1'b0; dir = 1'b0; in_push = 1'b0; in_data = '0;
    out_pop = 1'b0; flag_clr = 1'b0;
    repeat (3) tick();
    cmp_on = 1'b1;
    check("rst_dreq", DREQ, 1'b0);
    check("rst_oe", DB_OE, 1'b0);
    check("rst_dbout", DB_OUT, 8'h00);
    check("rst_in_full", in_full, 1'b0);
    check("rst_out_empty", out_empty, 1'b1);
    check("rst_flags", {eop_seen, err}, 2'b00);
    RESET_N = 1'b1; tick();

    // 1: single device->memory byte
    in_push = 1'b1; in_data = 8'hA5; tick();
    in_push = 1'b0; enable = 1'b1; dir = 1'b0;
    check("t1_dreq_lat", DREQ, 1'b0);
    tick();
    check("t1_dreq_up", DREQ, 1'b1);
    enable = 1'b0; DACK = 1'b1; tick();
    check("t1_dreq_down", DREQ, 1'b0);
    IOR_N = 1'b0; #1;
    check("t1_oe", DB_OE, 1'b1);
    check("t1_dbout", DB_OUT, 8'hA5);
    tick();
    IOR_N = 1'b1; DACK = 1'b0; #1;
    check("t1_oe_off", DB_OE, 1'b0);
    tick();
    enable = 1'b1; tick(); tick();
    check("t1_in_empty", DREQ, 1'b0);
    enable = 1'b0;

    // 2: memory->device bytes until OUT is full
    dir = 1'b1; enable = 1'b1;
    dma_write(8'h3C);
    check("t2_out_nonempty", out_empty, 1'b0);
    check("t2_out_data", out_data, 8'h3C);
    for (int i = 0; i < DEPTH - 1; i++) dma_write(8'(8'h40 + i));
    repeat (3) tick();
    check("t2_full_no_dreq", DREQ, 1'b0);
    enable = 1'b0;
    begin
      automatic logic [7:0] exp_seq[DEPTH] = '{8'h3C, 8'h40, 8'h41, 8'h42};
      for (int i = 0; i < DEPTH; i++) begin
        check("t2_pop_order", out_data, exp_seq[i]);
        out_pop = 1'b1; tick(); out_pop = 1'b0;
      end
    end
    check("t2_drained", out_empty, 1'b1);

    // 3: EOP while requesting
    dir = 1'b1; enable = 1'b1;
    wait_dreq();
    EOP_N = 1'b0; enable = 1'b0; tick();
    check("t3_dreq", DREQ, 1'b0);
    check("t3_eop", eop_seen, 1'b1);
    check("t3_out_empty", out_empty, 1'b1);
    EOP_N = 1'b1; flag_clr = 1'b1; tick(); flag_clr = 1'b0;
    check("t3_clr", eop_seen, 1'b0);

    // 4: full IN with same-edge push/pop, then pointer wrap over 2*DEPTH reads
    dir = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin in_push = 1'b1; in_data = 8'(8'h10 + i); tick(); end
    in_data = 8'h99; tick(); in_push = 1'b0;
    check("t4_full", in_full, 1'b1);
    enable = 1'b1;
    dma_read(1'b1, 8'h14, 8'h10);
    check("t4_still_full", in_full, 1'b1);
    for (int k = 1; k < 2 * DEPTH; k++) dma_read(k <= 3, 8'(8'h14 + k), 8'(8'h10 + k));
    enable = 1'b0; tick();
    check("t4_empty", in_full, 1'b0);

    // 5: wrong-direction strobe, then one pop despite a long read strobe
    in_push = 1'b1; in_data = 8'h77; tick();
    in_data = 8'h78; tick(); in_push = 1'b0;
    dir = 1'b0; enable = 1'b1;
    wait_dreq();
    enable = 1'b0; DACK = 1'b1; tick();
    IOW_N = 1'b0; tick();
    IOW_N = 1'b1;
    check("t5_err", err, 1'b1);
    check("t5_no_push", out_empty, 1'b1);
    IOR_N = 1'b0; #1;
    check("t5_oe", DB_OE, 1'b1);
    check("t5_data", DB_OUT, 8'h77);
    tick(); tick(); tick();
    check("t5_oe_release", DB_OE, 1'b0);
    IOR_N = 1'b1; DACK = 1'b0; tick();
    enable = 1'b1;
    dma_read(1'b0, 8'h00, 8'h78);
    tick(); tick();
    check("t5_one_pop_only", DREQ, 1'b0);
    enable = 1'b0;
    flag_clr = 1'b1; tick(); flag_clr = 1'b0;
    check("t5_err_clr", err, 1'b0);

    // 6: asynchronous reset in the middle of a read strobe
    in_push = 1'b1; in_data = 8'h5A; tick(); in_push = 1'b0;
    dir = 1'b0; enable = 1'b1;
    wait_dreq();
    enable = 1'b0; DACK = 1'b1; tick();
    IOR_N = 1'b0; #1;
    check("t6_oe_before", DB_OE, 1'b1);
    #2 RESET_N = 1'b0; #1;
    check("t6_oe_rst", DB_OE, 1'b0);
    check("t6_dreq_rst", DREQ, 1'b0);
    check("t6_dbout_rst", DB_OUT, 8'h00);
    check("t6_in_rst", in_full, 1'b0);
    check("t6_out_rst", out_empty, 1'b1);
    DACK = 1'b0; IOR_N = 1'b1;
    tick();
    RESET_N = 1'b1; tick();
    enable = 1'b1; tick(); tick();
    check("t6_in_emptied", DREQ, 1'b0);
    enable = 1'b0;

    // Randomized traffic checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      enable   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      in_push  = ($urandom_range(0, 9) < 3);
      in_data  = 8'($urandom);
      out_pop  = ($urandom_range(0, 9) < 3);
      DACK     = ($urandom_range(0, 9) < 6);
      IOR_N    = ($urandom_range(0, 9) >= 3);
      IOW_N    = ($urandom_range(0, 9) >= 3);
      EOP_N    = ($urandom_range(0, 39) != 0);
      DB_IN    = 8'($urandom);
      flag_clr = ($urandom_range(0, 29) == 0);
      tick();
    end

    enable = 1'b0; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
    in_push = 1'b0; out_pop = 1'b0; flag_clr = 1'b0;
    repeat (3) tick();
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
